// File: rtl/hd_eval_arbiter_if.sv
// Request/response/evaluator bundle for hd_eval_arbiter.
// slave: the arbiter side; master: requesters, response consumer and evaluator.
interface hd_eval_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [WIDTH-1:0]         dp_x;
    logic [WIDTH-1:0]         dp_y;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [WIDTH-1:0]         rsp_data;
    logic [ID_W-1:0]          rsp_id;

    modport slave (
        input  req_valid, req_data, dp_y, rsp_ready,
        output req_ready, dp_x, rsp_valid, rsp_data, rsp_id
    );

    modport master (
        output req_valid, req_data, dp_y, rsp_ready,
        input  req_ready, dp_x, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/hd_eval_arbiter.sv
// Round-robin time-sharing of one combinational evaluator among NUM_REQ
// requesters. The winning operand is registered onto dp_x, dp_y is sampled
// EVAL_LAT cycles later, and the result is returned tagged with the winner's ID.
module hd_eval_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = 32,
    parameter int EVAL_LAT = 2,
    parameter int ID_W     = $clog2(NUM_REQ)
) (
    input  logic              clk,
    input  logic              rst,
    hd_eval_arbiter_if.slave  bus,
    output logic              busy
);
    localparam int CNT_W = (EVAL_LAT > 1) ? $clog2(EVAL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(EVAL_LAT - 1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W:0]    NUM_EXT  = (ID_W+1)'(NUM_REQ);

    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   dp_x;
    logic [WIDTH-1:0]   rsp_data;
    logic [ID_W-1:0]    rsp_id;
    logic               rsp_valid;

    logic [ID_W-1:0]    grant;
    logic               any_valid;
    logic [ID_W:0]      sum;
    logic [ID_W-1:0]    idx;
    logic [NUM_REQ-1:0] ready;

    // Round-robin search starting at rr_ptr; the wrap is explicit at NUM_REQ
    // so non-power-of-two counts never index past the last requester.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (sum >= NUM_EXT) begin
                sum = sum - NUM_EXT;
            end
            idx = sum[ID_W-1:0];
            if (!any_valid && bus.req_valid[idx]) begin
                any_valid = 1'b1;
                grant     = idx;
            end
        end
    end

    // Accept strobe: one-hot grant, only while idle and out of reset.
    always_comb begin
        ready = '0;
        if (!rst && state == IDLE && any_valid) begin
            ready[grant] = 1'b1;
        end
    end

    // Transaction FSM: accept, count down the evaluation window, hold response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cnt       <= '0;
            dp_x      <= '0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        dp_x   <= bus.req_data[int'(grant)*WIDTH +: WIDTH];
                        rsp_id <= grant;
                        cnt    <= CNT_INIT;
                        busy   <= 1'b1;
                        state  <= EVAL;
                    end
                end
                EVAL: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        rsp_data  <= bus.dp_y;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_valid && bus.rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        rr_ptr    <= (rsp_id == LAST_ID) ? '0 : rsp_id + ID_W'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready;
    assign bus.dp_x      = dp_x;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = rsp_data;
    assign bus.rsp_id    = rsp_id;
endmodule

// File: tb/tb_hd_eval_arbiter.sv
// Bench for hd_eval_arbiter: a cycle table on a 4-requester, EVAL_LAT=2 build
// plus hand sequences for stall, reset mid-EVAL and a 3-requester EVAL_LAT=1 build.
module tb_hd_eval_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic busy4, busy3;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hd_eval_arbiter_if #(.NUM_REQ(4), .WIDTH(32), .ID_W(2)) bus4 ();
    hd_eval_arbiter_if #(.NUM_REQ(3), .WIDTH(32), .ID_W(2)) bus3 ();

    assign bus4.dp_y = ~bus4.dp_x;
    assign bus3.dp_y = ~bus3.dp_x;

    hd_eval_arbiter #(.NUM_REQ(4), .WIDTH(32), .EVAL_LAT(2), .ID_W(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus4),
        .busy (busy4)
    );

    hd_eval_arbiter #(.NUM_REQ(3), .WIDTH(32), .EVAL_LAT(1), .ID_W(2)) dut3 (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus3),
        .busy (busy3)
    );

    typedef struct {
        logic        rst;
        logic        sel;
        logic [3:0]  rv;
        logic        rrdy;
        logic [3:0]  e_ready;
        logic        e_rv;
        logic [31:0] e_data;
        logic [1:0]  e_id;
        logic        e_busy;
        logic [31:0] e_dpx;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic s, input logic [3:0] rv,
                                input logic rr, input logic [3:0] er, input logic ev,
                                input logic [31:0] ed, input logic [1:0] ei,
                                input logic eb, input logic [31:0] ex);
        vec_t t;
        t.rst = r; t.sel = s; t.rv = rv; t.rrdy = rr;
        t.e_ready = er; t.e_rv = ev; t.e_data = ed; t.e_id = ei;
        t.e_busy = eb; t.e_dpx = ex;
        vecs.push_back(t);
    endfunction

    function automatic logic [127:0] data_set(input logic sel);
        if (sel) return {32'h0, 32'h0, 32'h0000_00F0, 32'h0};
        return {32'h44, 32'h33, 32'h22, 32'h11};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        int  n;
        bit  seen;
        rst = 1'b1;
        bus4.req_valid = '0; bus4.req_data = data_set(1'b0); bus4.rsp_ready = 1'b0;
        bus3.req_valid = '0; bus3.req_data = {32'hA2, 32'hA1, 32'hA0}; bus3.rsp_ready = 1'b0;

        // rst sel rv rrdy | ready rv data id busy dp_x
        // single request from requester 1, result ~0xF0
        add(1, 0, 4'b1111, 0, 4'b0000, 0, 32'h0,        0, 0, 32'h0);
        add(0, 1, 4'b0010, 1, 4'b0010, 0, 32'h0,        0, 0, 32'h0);
        add(0, 1, 4'b0000, 1, 4'b0000, 0, 32'h0,        1, 1, 32'hF0);
        add(0, 1, 4'b0000, 1, 4'b0000, 0, 32'h0,        1, 1, 32'hF0);
        add(0, 1, 4'b0000, 1, 4'b0000, 1, 32'hFFFFFF0F, 1, 1, 32'hF0);
        add(0, 1, 4'b0000, 1, 4'b0000, 0, 32'hFFFFFF0F, 1, 0, 32'hF0);
        // all four valid: served 0,1,2,3, one every 4 cycles
        add(1, 0, 4'b0000, 1, 4'b0000, 0, 32'h0,        0, 0, 32'h0);
        add(0, 0, 4'b1111, 1, 4'b0001, 0, 32'h0,        0, 0, 32'h0);
        add(0, 0, 4'b1111, 1, 4'b0000, 0, 32'h0,        0, 1, 32'h11);
        add(0, 0, 4'b1111, 1, 4'b0000, 0, 32'h0,        0, 1, 32'h11);
        add(0, 0, 4'b1111, 1, 4'b0000, 1, 32'hFFFFFFEE, 0, 1, 32'h11);
        add(0, 0, 4'b1111, 1, 4'b0010, 0, 32'hFFFFFFEE, 0, 0, 32'h11);
        add(0, 0, 4'b1111, 1, 4'b0000, 0, 32'hFFFFFFEE, 1, 1, 32'h22);
        add(0, 0, 4'b1111, 1, 4'b0000, 0, 32'hFFFFFFEE, 1, 1, 32'h22);
        add(0, 0, 4'b1111, 1, 4'b0000, 1, 32'hFFFFFFDD, 1, 1, 32'h22);
        add(0, 0, 4'b1111, 1, 4'b0100, 0, 32'hFFFFFFDD, 1, 0, 32'h22);
        add(0, 0, 4'b1111, 1, 4'b0000, 0, 32'hFFFFFFDD, 2, 1, 32'h33);
        add(0, 0, 4'b1111, 1, 4'b0000, 0, 32'hFFFFFFDD, 2, 1, 32'h33);
        add(0, 0, 4'b1111, 1, 4'b0000, 1, 32'hFFFFFFCC, 2, 1, 32'h33);
        add(0, 0, 4'b1111, 1, 4'b1000, 0, 32'hFFFFFFCC, 2, 0, 32'h33);
        add(0, 0, 4'b1111, 1, 4'b0000, 0, 32'hFFFFFFCC, 3, 1, 32'h44);
        add(0, 0, 4'b1111, 1, 4'b0000, 0, 32'hFFFFFFCC, 3, 1, 32'h44);
        add(0, 0, 4'b1111, 1, 4'b0000, 1, 32'hFFFFFFBB, 3, 1, 32'h44);
        add(0, 0, 4'b0000, 1, 4'b0000, 0, 32'hFFFFFFBB, 3, 0, 32'h44);
        // requester 2 served, then 0 and 3 together: 3 wins, then 0
        add(0, 0, 4'b0100, 1, 4'b0100, 0, 32'hFFFFFFBB, 3, 0, 32'h44);
        add(0, 0, 4'b1001, 1, 4'b0000, 0, 32'hFFFFFFBB, 2, 1, 32'h33);
        add(0, 0, 4'b1001, 1, 4'b0000, 0, 32'hFFFFFFBB, 2, 1, 32'h33);
        add(0, 0, 4'b1001, 1, 4'b0000, 1, 32'hFFFFFFCC, 2, 1, 32'h33);
        add(0, 0, 4'b1001, 1, 4'b1000, 0, 32'hFFFFFFCC, 2, 0, 32'h33);
        add(0, 0, 4'b1001, 1, 4'b0000, 0, 32'hFFFFFFCC, 3, 1, 32'h44);
        add(0, 0, 4'b1001, 1, 4'b0000, 0, 32'hFFFFFFCC, 3, 1, 32'h44);
        add(0, 0, 4'b1001, 1, 4'b0000, 1, 32'hFFFFFFBB, 3, 1, 32'h44);
        add(0, 0, 4'b1001, 1, 4'b0001, 0, 32'hFFFFFFBB, 3, 0, 32'h44);
        add(0, 0, 4'b0000, 1, 4'b0000, 0, 32'hFFFFFFBB, 0, 1, 32'h11);
        add(0, 0, 4'b0000, 1, 4'b0000, 0, 32'hFFFFFFBB, 0, 1, 32'h11);
        add(0, 0, 4'b0000, 1, 4'b0000, 1, 32'hFFFFFFEE, 0, 1, 32'h11);
        add(0, 0, 4'b0000, 1, 4'b0000, 0, 32'hFFFFFFEE, 0, 0, 32'h11);
        // lone requester 0 served again right after itself
        add(0, 0, 4'b0001, 1, 4'b0001, 0, 32'hFFFFFFEE, 0, 0, 32'h11);
        add(0, 0, 4'b0000, 1, 4'b0000, 0, 32'hFFFFFFEE, 0, 1, 32'h11);
        add(0, 0, 4'b0000, 1, 4'b0000, 0, 32'hFFFFFFEE, 0, 1, 32'h11);
        add(0, 0, 4'b0000, 1, 4'b0000, 1, 32'hFFFFFFEE, 0, 1, 32'h11);
        add(0, 0, 4'b0000, 1, 4'b0000, 0, 32'hFFFFFFEE, 0, 0, 32'h11);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst            = vecs[i].rst;
            bus4.req_valid = vecs[i].rv;
            bus4.req_data  = data_set(vecs[i].sel);
            bus4.rsp_ready = vecs[i].rrdy;
            #1;
            chk($sformatf("row%0d req_ready", i), 32'(bus4.req_ready), 32'(vecs[i].e_ready));
            chk($sformatf("row%0d rsp_valid", i), 32'(bus4.rsp_valid), 32'(vecs[i].e_rv));
            chk($sformatf("row%0d rsp_data", i),  bus4.rsp_data,       vecs[i].e_data);
            chk($sformatf("row%0d rsp_id", i),    32'(bus4.rsp_id),    32'(vecs[i].e_id));
            chk($sformatf("row%0d busy", i),      32'(busy4),          32'(vecs[i].e_busy));
            chk($sformatf("row%0d dp_x", i),      bus4.dp_x,           vecs[i].e_dpx);
        end

        // response stalled 5 cycles: everything held, no accept
        @(negedge clk); rst = 1'b1; bus4.req_valid = '0; bus4.rsp_ready = 1'b0;
        bus4.req_data = data_set(1'b0);
        @(negedge clk); rst = 1'b0; bus4.req_valid = 4'b0100;
        #1 chk("stall accept", 32'(bus4.req_ready), 32'h4);
        @(negedge clk); bus4.req_valid = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        for (int s = 0; s < 5; s++) begin
            #1;
            chk($sformatf("stall%0d rsp_valid", s), 32'(bus4.rsp_valid), 32'h1);
            chk($sformatf("stall%0d rsp_data", s),  bus4.rsp_data,       32'hFFFFFFCC);
            chk($sformatf("stall%0d rsp_id", s),    32'(bus4.rsp_id),    32'h2);
            chk($sformatf("stall%0d dp_x", s),      bus4.dp_x,           32'h33);
            chk($sformatf("stall%0d req_ready", s), 32'(bus4.req_ready), 32'h0);
            @(negedge clk);
        end
        bus4.rsp_ready = 1'b1;
        #1 chk("stall release rsp_valid", 32'(bus4.rsp_valid), 32'h1);
        @(negedge clk);
        #1;
        chk("stall done rsp_valid", 32'(bus4.rsp_valid), 32'h0);
        chk("stall done busy",      32'(busy4),          32'h0);
        chk("stall next grant",     32'(bus4.req_ready), 32'h8);

        // reset while EVAL with cnt=1: transaction dropped, rr_ptr back to 0
        @(negedge clk); rst = 1'b1; bus4.req_valid = '0;
        @(negedge clk); rst = 1'b0; bus4.req_valid = 4'b0100;
        #1 chk("midrst accept", 32'(bus4.req_ready), 32'h4);
        @(negedge clk); bus4.req_valid = '0;
        #1 chk("midrst eval busy", 32'(busy4), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("midrst dp_x",      bus4.dp_x,           32'h0);
        chk("midrst busy",      32'(busy4),          32'h0);
        chk("midrst rsp_id",    32'(bus4.rsp_id),    32'h0);
        chk("midrst rsp_valid", 32'(bus4.rsp_valid), 32'h0);
        chk("midrst req_ready", 32'(bus4.req_ready), 32'h0);
        @(negedge clk); bus4.req_valid = 4'b1010;
        @(negedge clk); rst = 1'b0;
        #1 chk("postrst grant", 32'(bus4.req_ready), 32'h2);
        seen = 1'b0;
        for (n = 0; n < 12 && !seen; n++) begin
            @(negedge clk);
            bus4.req_valid = '0;
            if (bus4.rsp_valid) seen = 1'b1;
        end
        chk("postrst rsp seen", 32'(seen), 32'h1);
        chk("postrst rsp_id",   32'(bus4.rsp_id), 32'h1);
        chk("postrst rsp_data", bus4.rsp_data,    32'hFFFFFFDD);

        // NUM_REQ=3, EVAL_LAT=1: response 2 cycles after accept, wrap 2 -> 0
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; bus3.req_valid = 3'b100; bus3.rsp_ready = 1'b1;
        #1 chk("n3 accept", 32'(bus3.req_ready), 32'h4);
        @(negedge clk); bus3.req_valid = '0;
        #1;
        chk("n3 eval rsp_valid", 32'(bus3.rsp_valid), 32'h0);
        chk("n3 eval busy",      32'(busy3),          32'h1);
        chk("n3 eval dp_x",      bus3.dp_x,           32'hA2);
        @(negedge clk);
        #1;
        chk("n3 rsp_valid", 32'(bus3.rsp_valid), 32'h1);
        chk("n3 rsp_data",  bus3.rsp_data,       32'hFFFFFF5D);
        chk("n3 rsp_id",    32'(bus3.rsp_id),    32'h2);
        @(negedge clk); bus3.req_valid = 3'b111;
        #1;
        chk("n3 wrap grant", 32'(bus3.req_ready), 32'h1);
        chk("n3 idle busy",  32'(busy3),          32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
